dense_layer_param: RTL and testbench
====================================

// Module: dense_layer_param
// PURPOSE
//  Parametrised fully-connected layer for the MNIST inference chain.
//  Sits after the pooling stage: takes the pooled feature vector, runs a serial MAC
//  over on-chip weights/biases and produces raw and activated neuron outputs.
//  Adds a runtime weight/bias load port, bias add, fixed-point rescale,
//  saturation, optional ReLU and a stall input.
// PARAMETERS
//  IN_N   196  number of input features
//  OUT_N  32   number of neurons
//  DW     16   signed width of inputs, weights and layer outputs
//  FRAC   0    right arithmetic shift applied to the sum before saturation
//  ACC_W  2*DW+$clog2(IN_N)+1  signed accumulator and bias width
// PORTS
//  clk         in   1            rising-edge clock
//  reset       in   1            asynchronous, active-low reset
//  enable      in   1            1 = advance MAC, 0 = hold all state (stall)
//  start       in   1            request a new pass; sampled in IDLE only
//  relu_en     in   1            sampled with start; 1 = ReLU on layer_out
//  in_vec      in   IN_N*DW      signed inputs, element i at [i*DW +: DW]
//  w_we        in   1            weight write strobe
//  w_addr      in   clog2(IN_N*OUT_N)  weight index = j*IN_N + i
//  w_data      in   DW           signed weight
//  b_we        in   1            bias write strobe
//  b_addr      in   clog2(OUT_N) bias index j
//  b_data      in   ACC_W        signed bias, same scale as the unshifted sum
//  busy        out  1            1 while in RUN
//  layer_done  out  1            one-cycle pulse when the last neuron is written
//  neuron_res  out  OUT_N*ACC_W  raw sums, neuron j at [j*ACC_W +: ACC_W]
//  layer_out   out  OUT_N*DW     activated, saturated outputs, neuron j at [j*DW +: DW]
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state IDLE; i, j and acc cleared; busy, layer_done = 0
//   - neuron_res, layer_out, and all weights and biases = 0
//   - takes effect immediately, including mid-pass; no layer_done pulse follows.
//  FSM states: IDLE, RUN.
//  IDLE:
//   - w_we/b_we write the addressed memory at the clock edge.
//   - When start=1, on the next edge: latch in_vec and relu_en; i=0, j=0, acc=0;
//     clear neuron_res and layer_out to 0; go to RUN.
//   - The start edge does not require enable.
//  RUN (only when enable=1):
//   - Each cycle: acc += x[i]*w[j*IN_N+i], with full-precision signed product and
//     sign extension to ACC_W.
//   - When i==IN_N-1: sum = acc + x[i]*w + bias[j].
//     - neuron_res[j] = sum
//     - layer_out[j] = act(sat(sum >>> FRAC)), where sat clamps to
//       [-2^(DW-1), 2^(DW-1)-1] and act maps negative to 0 when relu_en is latched.
//     - Then acc=0, i=0, j++.
//   - When j==OUT_N-1 and i==IN_N-1: go to IDLE; layer_done=1 for exactly one cycle.
//   - enable=0 freezes i, j, acc and the outputs; the stall lengthens latency
//     cycle-for-cycle.
//  Latency: with enable held at 1, layer_done rises IN_N*OUT_N edges after the
//   start-accepting edge. busy is high for those same IN_N*OUT_N cycles.
//  Ignored inputs: start while busy; w_we and b_we while busy (memory unchanged).
//  Output hold: outputs keep their values after done until the next accepted start.
//  Overflow: none inside acc by construction of ACC_W; saturation is applied only
//   at the output.
// TESTING (IN_N=4, OUT_N=2, DW=16, FRAC=0 unless stated)
//  1. x={1,2,3,4}, w row0 all 1, row1 all -1, biases 0, relu_en=0
//     -> neuron_res={10,-10}, layer_out={10,-10}, layer_done 8 cycles after start.
//  2. Same as 1 with relu_en=1 and bias0=5
//     -> neuron_res={15,-10}, layer_out={15,0}.
//  3. x all 32767, row0 w=32767, row1 w=-32768
//     -> layer_out={32767,-32768}, neuron_res={4294705156,-4294836224}.
//  4. FRAC=8, x={256,0,0,0}, w row0={512,0,0,0}
//     -> neuron_res[0]=131072, layer_out[0]=512.
//  5. Test 1 with enable=0 for 3 cycles mid-RUN
//     -> same results, layer_done at cycle 11, values frozen while stalled.
//  6. Reset pulse at cycle 4 of RUN
//     -> busy=0, outputs 0, no layer_done, weights 0.
//     Reload weights and restart -> test 1 results.
//     start or w_we pulsed while busy -> results unchanged.

Source files
------------

// File: rtl/dense_layer_param.sv
// Serial fully-connected layer: one MAC per enabled cycle over on-chip weights and biases,
// producing raw sums and rescaled, saturated, optionally rectified outputs.
module dense_layer_param #(
    parameter int IN_N  = 196,
    parameter int OUT_N = 32,
    parameter int DW    = 16,
    parameter int FRAC  = 0,
    parameter int ACC_W = 2*DW + $clog2(IN_N) + 1,
    localparam int NW   = IN_N*OUT_N,
    localparam int WA_W = (NW > 1) ? $clog2(NW) : 1,
    localparam int BA_W = (OUT_N > 1) ? $clog2(OUT_N) : 1,
    localparam int I_W  = (IN_N > 1) ? $clog2(IN_N) : 1,
    localparam int J_W  = BA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   relu_en,
    input  logic [IN_N*DW-1:0]     in_vec,
    input  logic                   w_we,
    input  logic [WA_W-1:0]        w_addr,
    input  logic [DW-1:0]          w_data,
    input  logic                   b_we,
    input  logic [BA_W-1:0]        b_addr,
    input  logic [ACC_W-1:0]       b_data,
    output logic                   busy,
    output logic                   layer_done,
    output logic [OUT_N*ACC_W-1:0] neuron_res,
    output logic [OUT_N*DW-1:0]    layer_out,
    output logic                   dbg_state
);

    // Handshake: start is a request taken only while busy=0; once taken, busy stays
    // high until the edge that raises the one-cycle layer_done pulse.
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic signed [DW-1:0]      r_w   [NW];
    logic signed [ACC_W-1:0]   r_b   [OUT_N];
    logic signed [DW-1:0]      r_x   [IN_N];
    logic signed [ACC_W-1:0]   r_res [OUT_N];
    logic        [DW-1:0]      r_out [OUT_N];
    logic                      r_relu;
    logic        [I_W-1:0]     r_i;
    logic        [J_W-1:0]     r_j;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_done;

    logic        [WA_W-1:0]    w_widx;
    logic signed [DW-1:0]      w_x;
    logic signed [DW-1:0]      w_wt;
    logic signed [2*DW-1:0]    w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_shift;
    logic        [DW-1:0]      w_sat;
    logic        [DW-1:0]      w_act;
    logic                      w_last_i;
    logic                      w_last_j;
    logic                      w_step;

    assign w_widx     = WA_W'(r_j) * WA_W'(IN_N) + WA_W'(r_i);
    assign w_x        = r_x[r_i];
    assign w_wt       = r_w[w_widx];
    assign w_prod     = w_x * w_wt;
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_acc_nxt  = r_acc + w_prod_ext;
    assign w_sum      = w_acc_nxt + r_b[r_j];
    assign w_shift    = w_sum >>> FRAC;
    assign w_last_i   = (r_i == I_W'(IN_N-1));
    assign w_last_j   = (r_j == J_W'(OUT_N-1));
    assign w_step     = (r_state == S_RUN) && enable;

    // Clamp the rescaled sum into the signed DW range before the activation.
    always_comb begin
        w_sat = w_shift[DW-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (w_shift < SAT_MIN) begin
            w_sat = {1'b1, {(DW-1){1'b0}}};
        end
    end

    assign w_act = (r_relu && w_sat[DW-1]) ? '0 : w_sat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN:  if (w_step && w_last_i && w_last_j) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_RUN);
        dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NW; k++) r_w[k] <= '0;
            for (int k = 0; k < OUT_N; k++) begin
                r_b[k]   <= '0;
                r_res[k] <= '0;
                r_out[k] <= '0;
            end
            for (int k = 0; k < IN_N; k++) r_x[k] <= '0;
            r_relu <= 1'b0;
            r_i    <= '0;
            r_j    <= '0;
            r_acc  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                // Memories are writable only between passes.
                if (w_we && (int'(w_addr) < NW)) r_w[w_addr] <= w_data;
                if (b_we && (int'(b_addr) < OUT_N)) r_b[b_addr] <= b_data;
                if (start) begin
                    for (int k = 0; k < IN_N; k++) r_x[k] <= in_vec[k*DW +: DW];
                    for (int k = 0; k < OUT_N; k++) begin
                        r_res[k] <= '0;
                        r_out[k] <= '0;
                    end
                    r_relu <= relu_en;
                    r_i    <= '0;
                    r_j    <= '0;
                    r_acc  <= '0;
                end
            end else if (enable) begin
                if (w_last_i) begin
                    r_res[r_j] <= w_sum;
                    r_out[r_j] <= w_act;
                    r_acc      <= '0;
                    r_i        <= '0;
                    r_j        <= w_last_j ? '0 : r_j + J_W'(1);
                    r_done     <= w_last_j;
                end else begin
                    r_acc <= w_acc_nxt;
                    r_i   <= r_i + I_W'(1);
                end
            end
        end
    end

    assign layer_done = r_done;

    always_comb begin
        neuron_res = '0;
        layer_out  = '0;
        for (int k = 0; k < OUT_N; k++) begin
            neuron_res[k*ACC_W +: ACC_W] = r_res[k];
            layer_out[k*DW +: DW]        = r_out[k];
        end
    end

endmodule

// File: tb/tb_dense_layer_param.sv
// Bench for dense_layer_param: two instances (FRAC=0 and FRAC=8) share all inputs and are
// compared each cycle against an arithmetic model of the layer.
module tb_dense_layer_param;

    localparam int IN_N   = 4;
    localparam int OUT_N  = 2;
    localparam int DW     = 16;
    localparam int ACC_W  = 2*DW + $clog2(IN_N) + 1;
    localparam int NW     = IN_N*OUT_N;
    localparam int FRAC_B = 8;

    logic                   clk;
    logic                   reset;
    logic                   enable;
    logic                   start;
    logic                   relu_en;
    logic [IN_N*DW-1:0]     in_vec;
    logic                   w_we;
    logic [2:0]             w_addr;
    logic [DW-1:0]          w_data;
    logic                   b_we;
    logic [0:0]             b_addr;
    logic [ACC_W-1:0]       b_data;
    logic                   busy_a, done_a, st_a;
    logic                   busy_b, done_b, st_b;
    logic [OUT_N*ACC_W-1:0] res_a, res_b;
    logic [OUT_N*DW-1:0]    out_a, out_b;

    int     n_checks;
    int     n_fail;
    int     m_w [NW];
    longint m_b [OUT_N];
    int     m_x [IN_N];
    bit     m_relu;

    dense_layer_param #(.IN_N(IN_N), .OUT_N(OUT_N), .DW(DW), .FRAC(0)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .relu_en(relu_en),
        .in_vec(in_vec), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we),
        .b_addr(b_addr), .b_data(b_data), .busy(busy_a), .layer_done(done_a),
        .neuron_res(res_a), .layer_out(out_a), .dbg_state(st_a)
    );

    dense_layer_param #(.IN_N(IN_N), .OUT_N(OUT_N), .DW(DW), .FRAC(FRAC_B)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .relu_en(relu_en),
        .in_vec(in_vec), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we),
        .b_addr(b_addr), .b_data(b_data), .busy(busy_b), .layer_done(done_b),
        .neuron_res(res_b), .layer_out(out_b), .dbg_state(st_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain dot product plus bias, then rescale, clamp, rectify.
    function automatic longint exp_res(input int j);
        longint s;
        s = m_b[j];
        for (int i = 0; i < IN_N; i++) s += longint'(m_x[i]) * longint'(m_w[j*IN_N + i]);
        return s;
    endfunction

    function automatic longint exp_out(input int j, input int frac);
        longint v;
        v = exp_res(j) >>> frac;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        if (m_relu && v < 0) v = 0;
        return v;
    endfunction

    function automatic logic signed [63:0] res_of(input bit sel, input int j);
        logic [ACC_W-1:0] t;
        t = sel ? res_b[j*ACC_W +: ACC_W] : res_a[j*ACC_W +: ACC_W];
        return {{(64-ACC_W){t[ACC_W-1]}}, t};
    endfunction

    function automatic logic signed [63:0] out_of(input bit sel, input int j);
        logic [DW-1:0] t;
        t = sel ? out_b[j*DW +: DW] : out_a[j*DW +: DW];
        return {{(64-DW){t[DW-1]}}, t};
    endfunction

    function automatic int rand_val();
        logic signed [15:0] t;
        case ($urandom_range(0, 5))
            0: return -32768;
            1: return 32767;
            2: return int'($urandom_range(0, 20)) - 10;
            default: begin
                t = 16'($urandom());
                return int'(t);
            end
        endcase
    endfunction

    task automatic check_outputs(input string tag, input int n_done);
        for (int j = 0; j < OUT_N; j++) begin
            check($sformatf("%s_res_a%0d", tag, j), res_of(0, j), (j < n_done) ? exp_res(j) : 0);
            check($sformatf("%s_out_a%0d", tag, j), out_of(0, j), (j < n_done) ? exp_out(j, 0) : 0);
            check($sformatf("%s_res_b%0d", tag, j), res_of(1, j), (j < n_done) ? exp_res(j) : 0);
            check($sformatf("%s_out_b%0d", tag, j), out_of(1, j), (j < n_done) ? exp_out(j, FRAC_B) : 0);
        end
    endtask

    task automatic check_ctrl(input string tag, input bit exp_busy, input bit exp_done);
        check({tag, "_busy_a"}, busy_a, exp_busy);
        check({tag, "_done_a"}, done_a, exp_done);
        check({tag, "_state_a"}, st_a, exp_busy);
        check({tag, "_busy_b"}, busy_b, exp_busy);
        check({tag, "_done_b"}, done_b, exp_done);
    endtask

    // Driver tasks: entered and left at a falling edge.
    task automatic write_w(input int a, input int d);
        w_we   = 1'b1;
        w_addr = 3'(a);
        w_data = 16'(d);
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic write_b(input int j, input longint v);
        b_we   = 1'b1;
        b_addr = 1'(j);
        b_data = ACC_W'(v);
        @(negedge clk);
        b_we = 1'b0;
    endtask

    task automatic load_all();
        for (int a = 0; a < NW; a++) write_w(a, m_w[a]);
        for (int j = 0; j < OUT_N; j++) write_b(j, m_b[j]);
    endtask

    task automatic pack_x();
        for (int i = 0; i < IN_N; i++) in_vec[i*DW +: DW] = 16'(m_x[i]);
    endtask

    task automatic set_test1();
        for (int i = 0; i < IN_N; i++) begin
            m_x[i]        = i + 1;
            m_w[i]        = 1;
            m_w[IN_N + i] = -1;
        end
        m_b[0] = 0;
        m_b[1] = 0;
    endtask

    // stall_mode: 0 none, 1 random, 2 three cycles after the fourth MAC.
    task automatic run_pass(input string tag, input bit relu, input int stall_mode, input bit noise);
        int e;
        int stalled;
        bit en;
        m_relu  = relu;
        pack_x();
        relu_en = relu;
        start   = 1'b1;
        enable  = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        start   = 1'b0;
        enable  = 1'b1;
        in_vec  = {$urandom(), $urandom()};
        relu_en = 1'($urandom_range(0, 1));
        e       = 0;
        stalled = 0;
        while (e < NW) begin
            check_ctrl({tag, "_run"}, 1'b1, 1'b0);
            check_outputs({tag, "_run"}, e / IN_N);
            en = 1'b1;
            if (stall_mode == 1 && $urandom_range(0, 3) == 0) en = 1'b0;
            if (stall_mode == 2 && e == 4 && stalled < 3) en = 1'b0;
            if (!en) stalled++;
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                w_we   = 1'($urandom_range(0, 1));
                w_addr = 3'($urandom_range(0, 7));
                w_data = 16'($urandom());
                b_we   = 1'($urandom_range(0, 1));
                b_addr = 1'($urandom_range(0, 1));
                b_data = ACC_W'($urandom());
            end
            enable = en;
            @(negedge clk);
            start = 1'b0;
            w_we  = 1'b0;
            b_we  = 1'b0;
            if (en) e++;
        end
        enable = 1'b1;
        check_ctrl({tag, "_done"}, 1'b0, 1'b1);
        check_outputs({tag, "_done"}, OUT_N);
        enable = 1'($urandom_range(0, 1));
        @(negedge clk);
        enable = 1'b1;
        check_ctrl({tag, "_hold"}, 1'b0, 1'b0);
        check_outputs({tag, "_hold"}, OUT_N);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        enable   = 1'b0;
        start    = 1'b0;
        relu_en  = 1'b0;
        in_vec   = '0;
        w_we     = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        b_we     = 1'b0;
        b_addr   = '0;
        b_data   = '0;
        m_relu   = 1'b0;
        for (int a = 0; a < NW; a++) m_w[a] = 0;
        for (int j = 0; j < OUT_N; j++) m_b[j] = 0;
        for (int i = 0; i < IN_N; i++) m_x[i] = 0;
        repeat (3) @(negedge clk);
        check_ctrl("rst", 1'b0, 1'b0);
        check_outputs("rst", 0);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        set_test1();
        load_all();
        run_pass("t1", 1'b0, 0, 1'b0);
        check("t1_res0", res_of(0, 0), 10);
        check("t1_res1", res_of(0, 1), -10);
        check("t1_out0", out_of(0, 0), 10);
        check("t1_out1", out_of(0, 1), -10);

        m_b[0] = 5;
        write_b(0, 5);
        run_pass("t2", 1'b1, 0, 1'b0);
        check("t2_res0", res_of(0, 0), 15);
        check("t2_res1", res_of(0, 1), -10);
        check("t2_out0", out_of(0, 0), 15);
        check("t2_out1", out_of(0, 1), 0);

        for (int i = 0; i < IN_N; i++) begin
            m_x[i]        = 32767;
            m_w[i]        = 32767;
            m_w[IN_N + i] = -32768;
        end
        m_b[0] = 0;
        m_b[1] = 0;
        load_all();
        run_pass("t3", 1'b0, 0, 1'b0);
        check("t3_res0", res_of(0, 0), 64'sd4294705156);
        check("t3_res1", res_of(0, 1), -64'sd4294836224);
        check("t3_out0", out_of(0, 0), 32767);
        check("t3_out1", out_of(0, 1), -32768);

        for (int a = 0; a < NW; a++) m_w[a] = 0;
        for (int i = 0; i < IN_N; i++) m_x[i] = 0;
        m_x[0] = 256;
        m_w[0] = 512;
        load_all();
        run_pass("t4", 1'b0, 0, 1'b0);
        check("t4_res0_b", res_of(1, 0), 131072);
        check("t4_out0_b", out_of(1, 0), 512);

        set_test1();
        load_all();
        run_pass("t5", 1'b0, 2, 1'b0);

        // Reset in the middle of a pass.
        m_relu  = 1'b0;
        pack_x();
        relu_en = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_ctrl("t6_pre", 1'b1, 1'b0);
            @(negedge clk);
        end
        reset = 1'b0;
        for (int a = 0; a < NW; a++) m_w[a] = 0;
        for (int j = 0; j < OUT_N; j++) m_b[j] = 0;
        #1;
        check_ctrl("t6_rst", 1'b0, 1'b0);
        check_outputs("t6_rst", 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_ctrl("t6_after", 1'b0, 1'b0);
        check_outputs("t6_after", 0);
        for (int i = 0; i < IN_N; i++) m_x[i] = rand_val();
        run_pass("t6_zero", 1'b0, 0, 1'b0);
        set_test1();
        load_all();
        run_pass("t6_reload", 1'b0, 0, 1'b1);
        check("t6_res0", res_of(0, 0), 10);
        check("t6_res1", res_of(0, 1), -10);

        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < IN_N; i++) m_x[i] = rand_val();
            for (int a = 0; a < NW; a++) m_w[a] = rand_val();
            for (int j = 0; j < OUT_N; j++)
                m_b[j] = ($urandom_range(0, 1) == 1) ? longint'(int'($urandom()))
                                                      : longint'($urandom_range(0, 200)) - 100;
            load_all();
            run_pass($sformatf("rnd%0d", p), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
